// File: rtl/timer_bank_if.sv
// Bus bundle between the control unit and timer_bank: load/ack strobes in,
// selected count, timeout flags and interrupt out.
interface timer_bank_if #(
   parameter int DATA_WIDTH = 16,
   parameter int CHANNELS   = 4,
   parameter int SEL_WIDTH  = 2
);
   logic [DATA_WIDTH-1:0] DATA;
   logic                  timer_in;
   logic [SEL_WIDTH-1:0]  timer_select;
   logic                  timer_mode;
   logic [CHANNELS-1:0]   timer_ack;
   logic [SEL_WIDTH-1:0]  read_select;
   logic [DATA_WIDTH-1:0] count_out;
   logic [CHANNELS-1:0]   timeout;
   logic                  irq;

   modport master (
      output DATA, timer_in, timer_select, timer_mode, timer_ack, read_select,
      input  count_out, timeout, irq
   );

   modport slave (
      input  DATA, timer_in, timer_select, timer_mode, timer_ack, read_select,
      output count_out, timeout, irq
   );
endinterface

// File: rtl/timer_bank.sv
// Multi-channel down-counting timer bank with one-shot/periodic modes and sticky timeouts.
// Define TIMER_BANK_PRESCALE_EN to gate the shared tick with a PRESCALE-cycle prescaler.
module timer_bank #(
   parameter int DATA_WIDTH = 16,
   parameter int CHANNELS   = 4,
   parameter int SEL_WIDTH  = 2,
   parameter int PRESCALE   = 8
) (
   input logic         clk,
   input logic         reset,
   timer_bank_if.slave bus
);

   if (CHANNELS < 1 || CHANNELS > 16 || (2 ** SEL_WIDTH) < CHANNELS || PRESCALE < 1) begin : gParamCheck
      $error("timer_bank: illegal CHANNELS/SEL_WIDTH/PRESCALE combination");
   end

   logic tick;

`ifdef TIMER_BANK_PRESCALE_EN
   localparam int PsWidth = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PsWidth-1:0] PsLast = PsWidth'(PRESCALE - 1);

   logic [PsWidth-1:0] prescale_q;
   logic [PsWidth-1:0] prescale_d;

   // Free-running from reset; loads never restart it.
   assign tick       = (prescale_q == PsLast);
   assign prescale_d = tick ? '0 : prescale_q + PsWidth'(1);

   always_ff @(posedge clk) begin
      if (!reset) begin
         prescale_q <= '0;
      end else begin
         prescale_q <= prescale_d;
      end
   end
`else
   assign tick = 1'b1;
`endif

   logic [DATA_WIDTH-1:0] count_q  [CHANNELS];
   logic [DATA_WIDTH-1:0] count_d  [CHANNELS];
   logic [DATA_WIDTH-1:0] reload_q [CHANNELS];
   logic [DATA_WIDTH-1:0] reload_d [CHANNELS];
   logic [CHANNELS-1:0]   mode_q;
   logic [CHANNELS-1:0]   mode_d;
   logic [CHANNELS-1:0]   running_q;
   logic [CHANNELS-1:0]   running_d;
   logic [CHANNELS-1:0]   timeout_q;
   logic [CHANNELS-1:0]   timeout_d;
   logic                  loadValid;

   assign loadValid = bus.timer_in && (32'(bus.timer_select) < CHANNELS);

   // Ack is applied first, expiry may override it, and a load overrides both.
   always_comb begin
      mode_d    = mode_q;
      running_d = running_q;
      timeout_d = timeout_q & ~bus.timer_ack;
      for (int c = 0; c < CHANNELS; c++) begin
         count_d[c]  = count_q[c];
         reload_d[c] = reload_q[c];
         if (running_q[c] && tick) begin
            if (count_q[c] == DATA_WIDTH'(1)) begin
               timeout_d[c] = 1'b1;
               if (mode_q[c]) begin
                  count_d[c] = reload_q[c];
               end else begin
                  count_d[c]   = '0;
                  running_d[c] = 1'b0;
               end
            end else begin
               count_d[c] = count_q[c] - DATA_WIDTH'(1);
            end
         end
         if (loadValid && (32'(bus.timer_select) == c)) begin
            count_d[c]   = bus.DATA;
            reload_d[c]  = bus.DATA;
            mode_d[c]    = bus.timer_mode;
            running_d[c] = (bus.DATA != '0);
            timeout_d[c] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int c = 0; c < CHANNELS; c++) begin
            count_q[c]  <= '0;
            reload_q[c] <= '0;
         end
         mode_q    <= '0;
         running_q <= '0;
         timeout_q <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            count_q[c]  <= count_d[c];
            reload_q[c] <= reload_d[c];
         end
         mode_q    <= mode_d;
         running_q <= running_d;
         timeout_q <= timeout_d;
      end
   end

   // Out-of-range read selects fall through to zero.
   always_comb begin
      bus.count_out = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (32'(bus.read_select) == c) begin
            bus.count_out = count_q[c];
         end
      end
   end

   assign bus.timeout = timeout_q;
   assign bus.irq     = |timeout_q;

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank: expectations are queued with each stimulus
// and drained one cycle later, just after the clock edge that produces them.
module tb_timer_bank;
   localparam int DataWidth = 16;
   localparam int Channels  = 4;
   localparam int SelWidth  = 3;
   localparam int Prescale  = 8;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   timer_bank_if #(.DATA_WIDTH(DataWidth), .CHANNELS(Channels), .SEL_WIDTH(SelWidth)) bus ();

   timer_bank #(
      .DATA_WIDTH(DataWidth),
      .CHANNELS(Channels),
      .SEL_WIDTH(SelWidth),
      .PRESCALE(Prescale)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   typedef enum int {SigCount, SigTimeout, SigIrq} sig_e;
   typedef struct {
      string       tag;
      sig_e        sig;
      logic [31:0] value;
   } expect_t;

   expect_t sbQueue[$];
   int checkCount = 0;
   int errorCount = 0;
   int edgeCount  = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic expectOutput(input string tag, input sig_e sig, input logic [31:0] value);
      expect_t e;
      e.tag   = tag;
      e.sig   = sig;
      e.value = value;
      sbQueue.push_back(e);
   endtask

   task automatic expectState(input string tag, input int count, input int timeout);
      expectOutput({tag, ".count"}, SigCount, 32'(count));
      expectOutput({tag, ".timeout"}, SigTimeout, 32'(timeout));
      expectOutput({tag, ".irq"}, SigIrq, (timeout != 0) ? 32'd1 : 32'd0);
   endtask

   task automatic drainScoreboard();
      expect_t e;
      logic [31:0] obs;
      while (sbQueue.size() != 0) begin
         e = sbQueue.pop_front();
         case (e.sig)
            SigCount:   obs = 32'(bus.count_out);
            SigTimeout: obs = 32'(bus.timeout);
            default:    obs = 32'(bus.irq);
         endcase
         checkOutput(e.tag, obs, e.value);
      end
   endtask

   // Drives one cycle of inputs, waits for the edge and checks what was queued.
   task automatic applyStimulus(input logic load, input int sel, input int data, input logic mode,
                                input logic [Channels-1:0] ack, input int rsel);
      bus.timer_in     = load;
      bus.timer_select = SelWidth'(sel);
      bus.DATA         = DataWidth'(data);
      bus.timer_mode   = mode;
      bus.timer_ack    = ack;
      bus.read_select  = SelWidth'(rsel);
      @(posedge clk);
      #1;
      edgeCount++;
      drainScoreboard();
   endtask

   task automatic idle(input int rsel);
      applyStimulus(1'b0, 0, 0, 1'b0, '0, rsel);
   endtask

`ifdef TIMER_BANK_PRESCALE_EN
   // Ticks land on every Prescale-th edge counted from reset release.
   task automatic runPrescale();
      int ticks;
      int firstObs;
      ticks    = 0;
      firstObs = -1;
      expectState("ps.load", 2, 0);
      applyStimulus(1'b1, 0, 2, 1'b0, '0, 0);
      for (int k = 1; k <= 20; k++) begin
         if (((edgeCount + 1) % Prescale) == 0) ticks++;
         expectState($sformatf("ps.k%0d", k), (ticks == 0) ? 2 : (ticks == 1) ? 1 : 0, (ticks >= 2) ? 1 : 0);
         idle(0);
         if (bus.timeout[0] && firstObs < 0) firstObs = k;
      end
      checkOutput("ps.window", 32'(firstObs >= 9 && firstObs <= 16), 32'd1);
   endtask
`else
   task automatic runOneShot();
      expectState("os.load", 5, 0);
      applyStimulus(1'b1, 0, 5, 1'b0, '0, 0);
      for (int k = 1; k <= 4; k++) begin
         expectState($sformatf("os.count%0d", k), 5 - k, 0);
         idle(0);
      end
      expectState("os.expire", 0, 1);
      idle(0);
      for (int k = 0; k < 3; k++) begin
         expectState($sformatf("os.hold%0d", k), 0, 1);
         idle(0);
      end
      expectState("os.ack", 0, 0);
      applyStimulus(1'b0, 0, 0, 1'b0, 4'b0001, 0);
   endtask

   // Acks arrive the cycle after each expiry; expiries land every third edge.
   task automatic runPeriodic();
      expectState("per.load", 3, 0);
      applyStimulus(1'b1, 2, 3, 1'b1, '0, 2);
      for (int k = 1; k <= 10; k++) begin
         expectState($sformatf("per.k%0d", k), 3 - (k % 3), ((k % 3) == 0) ? 4 : 0);
         applyStimulus(1'b0, 0, 0, 1'b0, (k > 1 && ((k - 1) % 3) == 0) ? 4'b0100 : 4'b0000, 2);
      end
      expectState("per.stop", 0, 0);
      applyStimulus(1'b1, 2, 0, 1'b0, '0, 2);
   endtask

   task automatic runConflicts();
      expectState("cfA.load", 2, 0);
      applyStimulus(1'b1, 1, 2, 1'b0, '0, 1);
      expectState("cfA.one", 1, 0);
      idle(1);
      expectState("cfA.ackExpire", 0, 2);
      applyStimulus(1'b0, 0, 0, 1'b0, 4'b0010, 1);
      expectState("cfB.load", 2, 0);
      applyStimulus(1'b1, 1, 2, 1'b1, '0, 1);
      expectState("cfB.one", 1, 0);
      idle(1);
      expectState("cfB.loadExpire", 7, 0);
      applyStimulus(1'b1, 1, 7, 1'b1, '0, 1);
      expectState("cfB.stop", 0, 0);
      applyStimulus(1'b1, 1, 0, 1'b0, '0, 1);
   endtask

   task automatic runStopAndRange();
      int readSeq[6] = '{1, 2, 3, 4, 7, 0};
      expectState("stop.load", 10, 0);
      applyStimulus(1'b1, 3, 10, 1'b1, '0, 3);
      expectState("stop.c9", 9, 0);
      idle(3);
      expectState("stop.c8", 8, 0);
      idle(3);
      expectState("stop.zero", 0, 0);
      applyStimulus(1'b1, 3, 0, 1'b1, '0, 3);
      for (int k = 0; k < 12; k++) begin
         expectState($sformatf("stop.idle%0d", k), 0, 0);
         idle(3);
      end
      expectState("oor.load", 20, 0);
      applyStimulus(1'b1, 0, 20, 1'b1, '0, 0);
      expectState("oor.sel4", 19, 0);
      applyStimulus(1'b1, 4, 3, 1'b0, '0, 0);
      for (int k = 2; k <= 7; k++) begin
         expectState($sformatf("oor.read%0d", readSeq[k-2]), (readSeq[k-2] == 0) ? 20 - k : 0, 0);
         idle(readSeq[k-2]);
      end
      expectState("oor.stop", 0, 0);
      applyStimulus(1'b1, 0, 0, 1'b0, '0, 0);
   endtask

   task automatic runResetMidCount();
      expectState("rst.load", 3, 0);
      applyStimulus(1'b1, 0, 3, 1'b0, '0, 0);
      expectState("rst.c2", 2, 0);
      idle(0);
      reset = 1'b0;
      expectState("rst.assert", 0, 0);
      idle(0);
      reset = 1'b1;
      for (int k = 0; k < 5; k++) begin
         expectState($sformatf("rst.after%0d", k), 0, 0);
         idle(0);
      end
   endtask
`endif

   initial begin
      reset            = 1'b0;
      bus.timer_in     = 1'b1;
      bus.timer_select = '0;
      bus.DATA         = '1;
      bus.timer_mode   = 1'b1;
      bus.timer_ack    = '1;
      bus.read_select  = '0;
      for (int i = 0; i < Channels; i++) begin
         bus.read_select = SelWidth'(i);
         expectState($sformatf("reset.ch%0d", i), 0, 0);
         @(posedge clk);
         #1;
         drainScoreboard();
      end

      bus.timer_in   = 1'b0;
      bus.DATA       = '0;
      bus.timer_mode = 1'b0;
      bus.timer_ack  = '0;
      reset          = 1'b1;
      edgeCount      = 0;
      for (int i = 0; i < 50; i++) begin
         expectState($sformatf("idle%0d", i), 0, 0);
         idle(i % Channels);
      end

`ifdef TIMER_BANK_PRESCALE_EN
      runPrescale();
`else
      runOneShot();
      runPeriodic();
      runConflicts();
      runStopAndRange();
      runResetMidCount();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end
endmodule
